cp_instr_sequencer: RTL and testbench

//  Issues a stored program of 22-bit coprocessor instructions in order, one per coprocessor

---
 rtl/cp_seq_pkg.sv | 41 ++++
 rtl/cp_prog_mem.sv | 27 ++
 rtl/cp_instr_sequencer.sv | 145 ++++++++++++++
 tb/tb_cp_instr_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp_seq_pkg.sv
// cp_seq_pkg: shared state encoding, opcodes and instruction field positions for the sequencer
package cp_seq_pkg;

   localparam int INSTR_W_DEF = 22;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b10;
   localparam logic [1:0] OP_SUM   = 2'b11;

   localparam int OP_MSB   = 21;
   localparam int OP_LSB   = 20;
   localparam int DATA_MSB = 19;
   localparam int DATA_LSB = 12;
   localparam int MAT_MSB  = 11;
   localparam int MAT_LSB  = 10;
   localparam int ROW_MSB  = 9;
   localparam int ROW_LSB  = 7;
   localparam int COL_MSB  = 6;
   localparam int COL_LSB  = 4;
   localparam int SIZE_MSB = 3;
   localparam int SIZE_LSB = 0;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_ISSUE  = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_HOLD   = 3'd4;
   localparam logic [2:0] ST_FINISH = 3'd5;
   localparam logic [2:0] ST_ERR    = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_FETCH  = ST_FETCH,
      S_ISSUE  = ST_ISSUE,
      S_WAIT   = ST_WAIT,
      S_HOLD   = ST_HOLD,
      S_FINISH = ST_FINISH,
      S_ERR    = ST_ERR
   } state_e;

endpackage

// File: rtl/cp_prog_mem.sv
// cp_prog_mem: DEPTH x W program RAM with synchronous write and a registered, enabled read port
module cp_prog_mem import cp_seq_pkg::*; #(
   parameter int W = INSTR_W_DEF,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [AW-1:0] wa_i,
   input  logic [W-1:0]  wd_i,
   input  logic          re_i,
   input  logic [AW-1:0] ra_i,
   output logic [W-1:0]  rd_o
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk)
      if (we_i) mem[wa_i] <= wd_i;

   // The read register doubles as the instruction bus, so it only loads when asked
   always_ff @(posedge clk or posedge rst)
      if (rst) rd_o <= '0;
      else if (re_i) rd_o <= mem[ra_i];

endmodule

// File: rtl/cp_instr_sequencer.sv
// cp_instr_sequencer: issues a stored program one instruction per coprocessor completion
// Optional single-step mode (HOLD state, step edge detect) enabled by defining CP_SINGLE_STEP_EN.
module cp_instr_sequencer import cp_seq_pkg::*; #(
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int DEPTH = 16,
   parameter int TIMEOUT = 1023,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1,
   localparam int TW = $clog2(TIMEOUT + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               prog_we,
   input  logic [INSTR_W-1:0] prog_data,
   input  logic               prog_clr,
   output logic               prog_full,
   input  logic               run,
   input  logic               abort,
   input  logic               step,
   output logic [INSTR_W-1:0] cp_instr,
   output logic               cp_start,
   input  logic               cp_done,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [AW-1:0]      pc
);

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q, err_d;
   logic          busy_q, start_q, done_q;
   logic          idle, last, wr_en, rd_en;

   assign idle      = state_q == S_IDLE;
   assign last      = {1'b0, pc_q} == count_q - 1'b1;
   assign prog_full = count_q == CW'(DEPTH);
   assign wr_en     = idle && !abort && !prog_clr && prog_we && !prog_full;
   assign rd_en     = state_q == S_FETCH && !abort;

`ifdef CP_SINGLE_STEP_EN
   logic step_q, step_pulse;
   always_ff @(posedge clk or posedge rst)
      if (rst) step_q <= 1'b0;
      else step_q <= step;
   assign step_pulse = step && !step_q;
`else
   logic unused_step;
   assign unused_step = step;
`endif

   cp_prog_mem #(.W(INSTR_W), .DEPTH(DEPTH)) u_mem (
      .clk  (clk),
      .rst  (rst),
      .we_i (wr_en),
      .wa_i (count_q[AW-1:0]),
      .wd_i (prog_data),
      .re_i (rd_en),
      .ra_i (pc_q),
      .rd_o (cp_instr)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      count_d = count_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      if (abort) state_d = S_IDLE;
      else
         case (state_q)
            S_IDLE, S_ERR: begin
               if (idle && prog_clr) count_d = '0;
               else if (wr_en) count_d = count_q + 1'b1;
               if (run) begin
                  err_d = 1'b0;
                  if (count_q == '0) state_d = S_FINISH;
                  else begin
                     pc_d    = '0;
                     state_d = S_FETCH;
                  end
               end
            end
            S_FETCH: state_d = S_ISSUE;
            // The ISSUE cycle counts as the first timeout cycle
            S_ISSUE: begin
               tmo_d   = TW'(1);
               state_d = S_WAIT;
            end
            S_WAIT:
               if (cp_done) begin
                  if (last) state_d = S_FINISH;
                  else begin
`ifdef CP_SINGLE_STEP_EN
                     state_d = S_HOLD;
`else
                     pc_d    = pc_q + 1'b1;
                     state_d = S_FETCH;
`endif
                  end
               end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                  err_d   = 1'b1;
                  state_d = S_ERR;
               end else tmo_d = tmo_q + 1'b1;
`ifdef CP_SINGLE_STEP_EN
            S_HOLD:
               if (step_pulse) begin
                  pc_d    = pc_q + 1'b1;
                  state_d = S_FETCH;
               end
`endif
            default: state_d = S_IDLE;
         endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         count_q <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         busy_q  <= !(state_d inside {S_IDLE, S_ERR});
         start_q <= state_d == S_ISSUE;
         done_q  <= state_d == S_FINISH;
      end

   assign cp_start = start_q;
   assign done     = done_q;
   assign busy     = busy_q;
   assign err      = err_q;
   assign pc       = pc_q;

endmodule

// File: tb/tb_cp_instr_sequencer.sv
// tb_cp_instr_sequencer: event-timestamp model of the sequencer checked every cycle, plus directed literal pins
module tb_cp_instr_sequencer;

   localparam int W = 22;
   localparam int DEPTH = 16;
   localparam int T = 1023;

   logic         clk = 0, rst = 1, prog_we = 0, prog_clr = 0, run = 0, abort = 0, step = 0, cp_done = 0;
   logic [W-1:0] prog_data = '0;
   logic         prog_full, cp_start, busy, done, err;
   logic [W-1:0] cp_instr;
   logic [3:0]   pc;
   int           checks = 0, failures = 0;

   always #5 clk = ~clk;

   cp_instr_sequencer #(.INSTR_W(W), .DEPTH(DEPTH), .TIMEOUT(T)) dut (
      .clk(clk), .rst(rst), .prog_we(prog_we), .prog_data(prog_data), .prog_clr(prog_clr),
      .prog_full(prog_full), .run(run), .abort(abort), .step(step), .cp_instr(cp_instr),
      .cp_start(cp_start), .cp_done(cp_done), .busy(busy), .done(done), .err(err), .pc(pc)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
      end
   endtask

   // Model: program as a queue, outputs derived from the edge numbers at which events happen
   logic [W-1:0] m_prog[$];
   logic [W-1:0] m_instr = '0;
   int  cyc = 0, m_next = -1, m_start = -100, m_done_e = -100, m_idx = 0;
   bit  m_active = 0, m_wait = 0, m_in_err = 0, m_err = 0, m_hold = 0, m_step_prev = 0;

   always @(posedge clk) begin
      bit was_idle, was_err, spulse;
      int e;
      cyc++;
      e = cyc;
      spulse = step && !m_step_prev;
      m_step_prev = rst ? 1'b0 : step;
      if (rst) begin
         m_prog.delete();
         m_instr = '0; m_next = -1; m_start = -100; m_done_e = -100; m_idx = 0;
         m_active = 0; m_wait = 0; m_in_err = 0; m_err = 0; m_hold = 0;
      end else begin
         was_idle = !m_active && !m_in_err && m_done_e != e - 1;
         was_err  = m_in_err;
         if (abort) begin
            m_active = 0; m_wait = 0; m_hold = 0; m_next = -1; m_in_err = 0;
         end else begin
            if (e == m_next) begin
               m_start = e; m_wait = 1; m_instr = m_prog[m_idx]; m_next = -1;
            end else if (m_wait && e >= m_start + 2) begin
               if (cp_done) begin
                  m_wait = 0;
                  if (m_idx == m_prog.size() - 1) begin
                     m_active = 0; m_done_e = e;
                  end else begin
`ifdef CP_SINGLE_STEP_EN
                     m_hold = 1;
`else
                     m_idx++; m_next = e + 1;
`endif
                  end
               end else if (e == m_start + T) begin
                  m_wait = 0; m_active = 0; m_in_err = 1; m_err = 1;
               end
            end else if (m_hold && spulse) begin
               m_hold = 0; m_idx++; m_next = e + 1;
            end
            if ((was_idle || was_err) && run) begin
               m_err = 0; m_in_err = 0;
               if (m_prog.size() == 0) m_done_e = e;
               else begin
                  m_active = 1; m_idx = 0; m_next = e + 1;
               end
            end
            if (was_idle) begin
               if (prog_clr) m_prog.delete();
               else if (prog_we && m_prog.size() < DEPTH) m_prog.push_back(prog_data);
            end
         end
      end
   end

   logic [W-1:0] seen[$];
   int n_start = 0, n_done = 0;

   always @(negedge clk)
      if (!rst) begin
         chk("cp_start", cp_start, cyc == m_start);
         chk("done", done, cyc == m_done_e);
         chk("busy", busy, m_active || cyc == m_done_e);
         chk("err", err, m_err);
         chk("pc", pc, m_idx);
         chk("prog_full", prog_full, m_prog.size() == DEPTH);
         chk("cp_instr", cp_instr, m_instr);
         if (cp_start) begin
            n_start++;
            seen.push_back(cp_instr);
         end
         if (done) n_done++;
      end

   // Coprocessor stand-in: completes 5 cycles after each cp_start
   bit resp_en = 1, auto_step = 1;
   int rcnt = 0, scnt = 0;
   always @(posedge clk) begin
      #1;
      if (cp_start && resp_en) rcnt = 5;
      else if (rcnt > 0) rcnt--;
      cp_done = resp_en && rcnt == 1;
      if (cp_done) scnt = 3;
      else if (scnt > 0) scnt--;
      if (auto_step) step = scnt == 1;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load(input logic [W-1:0] d);
      prog_we = 1; prog_data = d; tick(); prog_we = 0;
   endtask

   task automatic clear;
      prog_clr = 1; tick(); prog_clr = 0;
   endtask

   task automatic pulse_run;
      run = 1; tick(); run = 0;
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int n = 0;
      while (busy && n < budget) begin
         tick(); n++;
      end
      chk(nm, busy, 0);
   endtask

   task automatic wait_start(input int budget, input string nm);
      int n = 0;
      while (!cp_start && n < budget) begin
         tick(); n++;
      end
      chk(nm, cp_start, 1);
   endtask

   initial begin
      int s, n;
      tick(3);
      rst = 0;
      tick();
      chk("rst_instr", cp_instr, 0);
      chk("rst_start", cp_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_pc", pc, 0);
      chk("rst_done", done, 0);
      chk("rst_full", prog_full, 0);

      // 1) three instructions, free-running
      load(22'h2FF002); load(22'h0FF042); load(22'h200092);
      seen.delete(); n_start = 0; n_done = 0;
      pulse_run();
      wait_idle(200, "t1_idle");
      tick(2);
      chk("t1_nstart", n_start, 3);
      chk("t1_i0", seen[0], 22'h2FF002);
      chk("t1_i1", seen[1], 22'h0FF042);
      chk("t1_i2", seen[2], 22'h200092);
      chk("t1_ndone", n_done, 1);
      chk("t1_pc", pc, 2);

      // 2) overfill: the 17th write is dropped
      clear();
      for (int i = 0; i < 17; i++) begin
         load(W'(22'h100000 + i));
         if (i == 14) chk("t2_notfull", prog_full, 0);
         if (i >= 15) chk("t2_full", prog_full, 1);
      end
      seen.delete(); n_start = 0;
      pulse_run();
      wait_idle(400, "t2_idle");
      tick(2);
      chk("t2_nstart", n_start, 16);
      chk("t2_last", seen[15], 22'h10000F);

      // 3) timeout, then a rerun clears err and reissues entry 0
      clear();
      load(22'h3A5123); load(22'h012345);
      resp_en = 0;
      pulse_run();
      wait_start(5, "t3_start");
      s = cyc; n = 0;
      while (!err && n < 1100) begin
         tick(); n++;
      end
      chk("t3_lat", cyc - s, T);
      chk("t3_busy", busy, 0);
      resp_en = 1;
      seen.delete(); n_start = 0;
      pulse_run();
      chk("t3_errclr", err, 0);
      wait_idle(200, "t3_idle");
      tick(2);
      chk("t3_rerun0", seen[0], 22'h3A5123);
      chk("t3_nstart", n_start, 2);

      // 4) abort while waiting on instruction 1
      clear();
      load(22'h0AAAAA); load(22'h155555); load(22'h3C3C3C);
      seen.delete(); n_start = 0;
      pulse_run();
      n = 0;
      while (n_start < 2 && n < 100) begin
         tick(); n++;
      end
      chk("t4_reach", n_start, 2);
      tick(1);
      resp_en = 0; abort = 1; tick(); abort = 0;
      chk("t4_busy", busy, 0);
      tick(20);
      chk("t4_nstart", n_start, 2);
      resp_en = 1;
      pulse_run();
      wait_start(5, "t4_start");
      chk("t4_pc", pc, 0);
      chk("t4_instr", cp_instr, 22'h0AAAAA);
      wait_idle(200, "t4_idle");

      // 5) empty program gives done without cp_start; async reset mid-WAIT
      clear();
      n_start = 0; n_done = 0;
      pulse_run();
      tick(3);
      chk("t5_ndone", n_done, 1);
      chk("t5_nstart", n_start, 0);
      load(22'h2FFFFF);
      resp_en = 0;
      pulse_run();
      tick(5);
      #2 rst = 1;
      #1;
      chk("t5_rinstr", cp_instr, 0);
      chk("t5_rbusy", busy, 0);
      chk("t5_rstart", cp_start, 0);
      chk("t5_rpc", pc, 0);
      tick();
      rst = 0;
      resp_en = 1;
      tick(2);

`ifdef CP_SINGLE_STEP_EN
      // 6) single step: second issue follows the step pulse by 2 cycles
      auto_step = 0; step = 0;
      load(22'h111111); load(22'h222222);
      n_start = 0;
      pulse_run();
      tick(15);
      chk("t6_hold", n_start, 1);
      step = 1; s = cyc; tick(); step = 0;
      wait_start(10, "t6_start");
      chk("t6_lat", cyc - s, 2);
      chk("t6_instr", cp_instr, 22'h222222);
      wait_idle(50, "t6_idle");
`endif

      tick(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
